// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types and constants for the VGA timing generator.
//   phase_e            - phase of one scan axis (active, front porch, sync, back porch)
//   DEF_*              - default 640x480@60 timing (25 MHz pixel clock)
//   clog2()            - counter width for a given number of states (minimum 1)
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SY  = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    // Smallest width w (>= 1) with 2**w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter plus phase FSM for one scan axis.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   advance   - step the counter by one position this clock
//   count     - current position, 0..ACTIVE+FRONT+SYNC+BACK-1
//   phase     - current phase (ACT -> FP -> SY -> BP -> ACT)
//   syncOut   - POL while in the sync phase, ~POL otherwise
//   wrap      - high when this advance takes count from its last value to 0
// Zero-width porches are skipped; SYNC must be at least 1.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK,
    parameter bit          POL    = 1'b0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          advance,
    output logic [clog2(ACTIVE+FRONT+SYNC+BACK)-1:0]      count,
    output phase_e                                        phase,
    output logic                                          syncOut,
    output logic                                          wrap
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam int unsigned CNT_W = clog2(TOTAL);

    // Last count value of each phase.
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] FP_END  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] SY_END  = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] TOT_END = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    assign wrap = advance && (count_q == TOT_END);

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (advance) begin
            count_d = wrap ? '0 : count_q + 1'b1;
            unique case (phase_q)
                PH_ACT: begin
                    if (count_q == ACT_END) begin
                        phase_d = (FRONT != 0) ? PH_FP : PH_SY;
                    end
                end
                PH_FP: begin
                    if (count_q == FP_END) begin
                        phase_d = PH_SY;
                    end
                end
                PH_SY: begin
                    if (count_q == SY_END) begin
                        phase_d = (BACK != 0) ? PH_BP : PH_ACT;
                    end
                end
                PH_BP: begin
                    if (count_q == TOT_END) begin
                        phase_d = PH_ACT;
                    end
                end
                default: phase_d = PH_ACT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= PH_ACT;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count   = count_q;
    assign phase   = phase_q;
    assign syncOut = (phase_q == PH_SY) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Divides clk by CLK_DIV to the pixel rate and produces registered syncs, visibility and
// coordinates for any mode. Each pixel is held for CLK_DIV clocks, starting in the clock
// where pixelEn is high.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   hSync, vSync   - syncs, asserted level HSYNC_POL / VSYNC_POL
//   row, column    - coordinates of the visible pixel, 0 during blanking
//   displayActive  - pixel at (row, column) is visible
//   pixelEn        - one-clock strobe marking the start of each pixel
//   lineStart      - high for the pixel at hCount 0
//   frameStart     - high for the pixel at hCount 0, vCount 0
// Optional macro VGA_SYNC_PIPE_EN: delays hSync, vSync and displayActive by PIPE_STAGES
// pixels; coordinates and start pulses stay undelayed.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned COL_W       = 10,
    parameter int unsigned ROW_W       = 9,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             hSync,
    output logic             vSync,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] column,
    output logic             displayActive,
    output logic             pixelEn,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = clog2(CLK_DIV);
    localparam int unsigned HC_W    = clog2(H_TOTAL);
    localparam int unsigned VC_W    = clog2(V_TOTAL);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_adv;

    // Counters step in the same clock the pixel at their current position is registered out.
    assign pix_adv = (div_q == '0);
    assign div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    logic [HC_W-1:0] h_count;
    logic [VC_W-1:0] v_count;
    phase_e          h_phase, v_phase;
    logic            h_sync, v_sync, h_wrap, v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .POL    (HSYNC_POL)
    ) u_hcount (
        .clk     (clk),
        .rst     (rst),
        .advance (pix_adv),
        .count   (h_count),
        .phase   (h_phase),
        .syncOut (h_sync),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .POL    (VSYNC_POL)
    ) u_vcount (
        .clk     (clk),
        .rst     (rst),
        .advance (h_wrap),
        .count   (v_count),
        .phase   (v_phase),
        .syncOut (v_sync),
        .wrap    (v_wrap_unused)
    );

    logic visible;
    assign visible = (h_phase == PH_ACT) && (v_phase == PH_ACT);

    logic             hsync_q, vsync_q, active_q, pix_en_q, line_start_q, frame_start_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            active_q      <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_adv;
            if (pix_adv) begin
                hsync_q       <= h_sync;
                vsync_q       <= v_sync;
                active_q      <= visible;
                row_q         <= visible ? ROW_W'(v_count) : '0;
                col_q         <= visible ? COL_W'(h_count) : '0;
                line_start_q  <= (h_count == '0);
                frame_start_q <= (h_count == '0) && (v_count == '0);
            end
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    // Delays syncs to line up with pixel data fetched using the undelayed coordinates.
    logic [PIPE_STAGES-1:0] hs_pipe_q, vs_pipe_q, act_pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe_q  <= {PIPE_STAGES{~HSYNC_POL}};
            vs_pipe_q  <= {PIPE_STAGES{~VSYNC_POL}};
            act_pipe_q <= '0;
        end else if (pix_adv) begin
            hs_pipe_q  <= (hs_pipe_q << 1) | PIPE_STAGES'(hsync_q);
            vs_pipe_q  <= (vs_pipe_q << 1) | PIPE_STAGES'(vsync_q);
            act_pipe_q <= (act_pipe_q << 1) | PIPE_STAGES'(active_q);
        end
    end

    assign hSync         = hs_pipe_q[PIPE_STAGES-1];
    assign vSync         = vs_pipe_q[PIPE_STAGES-1];
    assign displayActive = act_pipe_q[PIPE_STAGES-1];
`else
    localparam int unsigned unused_pipe_stages = PIPE_STAGES;

    assign hSync         = hsync_q;
    assign vSync         = vsync_q;
    assign displayActive = active_q;
`endif

    assign row        = row_q;
    assign column     = col_q;
    assign pixelEn    = pix_en_q;
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny active-high-sync instance
// run side by side. Every clock, expected outputs of both are derived arithmetically from
// the number of clocks since reset, queued, then popped and compared after the edge.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_PIPE_EN
    localparam int PIPE = 2;
`else
    localparam int PIPE = 0;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       pe;
        logic       ls;
        logic       fs;
        logic [9:0] row;
        logic [9:0] col;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_act, d_pe, d_ls, d_fs;
    logic [8:0] d_row;
    logic [9:0] d_col;
    logic       t_hs, t_vs, t_act, t_pe, t_ls, t_fs;
    logic [1:0] t_row;
    logic [2:0] t_col;

    vga_timing_gen dut (
        .clk           (clk),
        .rst           (rst),
        .hSync         (d_hs),
        .vSync         (d_vs),
        .row           (d_row),
        .column        (d_col),
        .displayActive (d_act),
        .pixelEn       (d_pe),
        .lineStart     (d_ls),
        .frameStart    (d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV   (1),
        .H_ACTIVE  (8),
        .H_FRONT   (1),
        .H_SYNC    (2),
        .H_BACK    (1),
        .V_ACTIVE  (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1),
        .HSYNC_POL (1'b1),
        .VSYNC_POL (1'b1),
        .COL_W     (3),
        .ROW_W     (2)
    ) dut_tiny (
        .clk           (clk),
        .rst           (rst),
        .hSync         (t_hs),
        .vSync         (t_vs),
        .row           (t_row),
        .column        (t_col),
        .displayActive (t_act),
        .pixelEn       (t_pe),
        .lineStart     (t_ls),
        .frameStart    (t_fs)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   k       = 0;
    obs_t exp_d_q[$];
    obs_t exp_t_q[$];

    // Expected outputs after the kk-th clock edge since reset released (kk = 0: in reset).
    function automatic obs_t model(int kk, int div, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, bit hp, bit vp);
        obs_t e;
        int   ht, vt, p, hc, vc, q, qh, qv;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        if (kk == 0) return e;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        p  = (kk - 1) / div;
        hc = p % ht;
        vc = (p / ht) % vt;
        e.pe = ((kk - 1) % div) == 0;
        e.ls = (hc == 0);
        e.fs = (hc == 0) && (vc == 0);
        if (hc < ha && vc < va) begin
            e.row = 10'(vc);
            e.col = 10'(hc);
        end
        if (p >= PIPE) begin
            q  = p - PIPE;
            qh = q % ht;
            qv = (q / ht) % vt;
            e.hs  = (qh >= ha + hf && qh < ha + hf + hsw) ? hp : ~hp;
            e.vs  = (qv >= va + vf && qv < va + vf + vsw) ? vp : ~vp;
            e.act = (qh < ha) && (qv < va);
        end
        return e;
    endfunction

    task automatic check(string tag, int obs, int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Directed timing measurements, taken from observed outputs.
    bit   meas_on = 1'b0;
    int   first_pe = -1, hs_fall = -1, hs_rise = -1, ls1 = -1, ls2 = -1;
    int   act_rise = -1, act_fall = -1, col_max = 0, col_after = -1;
    logic prev_hs = 1'b1, prev_ls = 1'b0, prev_act = 1'b0;
    logic [9:0] prev_col = '0;
    int   t_first = -1, t_hs_rise = -1, t_hs_fall = -1, t_ls1 = -1, t_ls2 = -1;
    int   t_fs1 = -1, t_fs2 = -1, t_vs_rise = -1, t_vs_fall = -1, t_pe_low = 0, t_row_max = 0;
    logic t_prev_hs = 1'b0, t_prev_vs = 1'b0, t_prev_ls = 1'b0, t_prev_fs = 1'b0;

    task automatic measure();
        if (d_pe && first_pe < 0) first_pe = cyc;
        if (first_pe >= 0) begin
            if (prev_hs && !d_hs && hs_fall < 0) hs_fall = cyc;
            if (!prev_hs && d_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = cyc;
            if (d_ls && !prev_ls) begin
                if (ls1 < 0) ls1 = cyc;
                else if (ls2 < 0) ls2 = cyc;
            end
            if (d_act && !prev_act && act_rise < 0) act_rise = cyc;
            if (!d_act && prev_act && act_fall < 0) act_fall = cyc;
            if (int'(d_col) > col_max) col_max = int'(d_col);
            if (prev_col == 10'd639 && d_col != 10'd639 && col_after < 0) col_after = int'(d_col);
        end
        if (t_pe && t_first < 0) t_first = cyc;
        if (t_first >= 0) begin
            if (!t_pe) t_pe_low++;
            if (!t_prev_hs && t_hs && t_hs_rise < 0) t_hs_rise = cyc;
            if (t_prev_hs && !t_hs && t_hs_rise >= 0 && t_hs_fall < 0) t_hs_fall = cyc;
            if (t_ls && !t_prev_ls) begin
                if (t_ls1 < 0) t_ls1 = cyc;
                else if (t_ls2 < 0) t_ls2 = cyc;
            end
            if (t_fs && !t_prev_fs) begin
                if (t_fs1 < 0) t_fs1 = cyc;
                else if (t_fs2 < 0) t_fs2 = cyc;
            end
            if (!t_prev_vs && t_vs && t_vs_rise < 0) t_vs_rise = cyc;
            if (t_prev_vs && !t_vs && t_vs_rise >= 0 && t_vs_fall < 0) t_vs_fall = cyc;
            if (int'(t_row) > t_row_max) t_row_max = int'(t_row);
        end
        prev_hs   = d_hs;
        prev_ls   = d_ls;
        prev_act  = d_act;
        prev_col  = d_col;
        t_prev_hs = t_hs;
        t_prev_vs = t_vs;
        t_prev_ls = t_ls;
        t_prev_fs = t_fs;
    endtask

    // One clock: queue expectations for the coming edge, then compare after it.
    task automatic step();
        obs_t ed, et, ad, at;
        if (rst) k = 0;
        else k++;
        exp_d_q.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        exp_t_q.push_back(model(k, 1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        cyc++;
        ad.hs = d_hs;  ad.vs = d_vs;  ad.act = d_act; ad.pe = d_pe;
        ad.ls = d_ls;  ad.fs = d_fs;  ad.row = 10'(d_row); ad.col = d_col;
        at.hs = t_hs;  at.vs = t_vs;  at.act = t_act; at.pe = t_pe;
        at.ls = t_ls;  at.fs = t_fs;  at.row = 10'(t_row); at.col = 10'(t_col);
        ed = exp_d_q.pop_front();
        et = exp_t_q.pop_front();
        n_tests++;
        assert (ad === ed) else begin
            n_fail++;
            $error("FAIL dflt_cyc%0d observed=%h expected=%h", cyc, ad, ed);
        end
        n_tests++;
        assert (at === et) else begin
            n_fail++;
            $error("FAIL tiny_cyc%0d observed=%h expected=%h", cyc, at, et);
        end
        if (meas_on) measure();
    endtask

    initial begin
        // Reset held for 25 clocks.
        rst = 1'b1;
        for (int i = 0; i < 25; i++) step();
        check("rst_hsync", int'(d_hs), 1);
        check("rst_vsync", int'(d_vs), 1);
        check("rst_active", int'(d_act), 0);
        check("rst_tiny_hsync", int'(t_hs), 0);

        // First pixel after release.
        rst = 1'b0;
        meas_on = 1'b1;
        step();
        check("first_pe", int'(d_pe), 1);
        check("first_fs", int'(d_fs), 1);
        check("first_row", int'(d_row), 0);
        check("first_col", int'(d_col), 0);
        check("first_active", int'(d_act), (PIPE == 0) ? 1 : 0);

        // Run into line 1, column 200.
        for (int i = 0; i < 4000 && !(d_row == 9'd1 && d_col == 10'd200); i++) step();
        meas_on = 1'b0;
        check("midline_reached", int'(d_row == 9'd1 && d_col == 10'd200), 1);

        check("hsync_fall_delay", hs_fall - first_pe, 1312 + 2 * PIPE);
        check("hsync_low_width", hs_rise - hs_fall, 192);
        check("line_start_first", ls1, first_pe);
        check("line_period", ls2 - ls1, 1600);
        check("active_lag", act_rise - first_pe, 2 * PIPE);
        check("active_width", act_fall - act_rise, 1280);
        check("col_max", col_max, 639);
        check("col_after_639", col_after, 0);

        check("tiny_pe_low", t_pe_low, 0);
        check("tiny_hsync_delay", t_hs_rise - t_first, 9 + PIPE);
        check("tiny_hsync_width", t_hs_fall - t_hs_rise, 2);
        check("tiny_line_period", t_ls2 - t_ls1, 12);
        check("tiny_frame_period", t_fs2 - t_fs1, 84);
        check("tiny_vsync_delay", t_vs_rise - t_first, 60 + PIPE);
        check("tiny_vsync_width", t_vs_fall - t_vs_rise, 12);
        check("tiny_row_max", t_row_max, 3);

        // Reset in the middle of a visible line.
        rst = 1'b1;
        step();
        check("midrst_hsync", int'(d_hs), 1);
        check("midrst_active", int'(d_act), 0);
        check("midrst_pe", int'(d_pe), 0);
        check("midrst_row", int'(d_row), 0);
        check("midrst_col", int'(d_col), 0);
        step();
        step();

        // Restart: frame begins again at (0,0), every clock compared against the model.
        rst = 1'b0;
        step();
        check("restart_fs", int'(d_fs), 1);
        check("restart_col", int'(d_col), 0);
        for (int i = 0; i < 1700; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
